// File: rtl/input_conditioner_if.sv
// Board-side bundle for input_conditioner: raw switches/buttons in, conditioned commands and time out.
interface input_conditioner_if;
    logic [14:0] sw;
    logic [3:0]  btn;
    logic        clear_pulse;
    logic        load_time_pulse;
    logic        load_alarm_pulse;
    logic        stop_alarm_pulse;
    logic [3:0]  minute_out0;
    logic [3:0]  minute_out1;
    logic [3:0]  hour_out0;
    logic [1:0]  hour_out1;
    logic        alarm_on;
    logic [3:0]  btn_level;
    logic        sw_invalid;

    // sw/btn are raw levels with no handshake; every pulse output is a single-cycle
    // strobe, and the time outputs are valid in the cycle a load pulse is high.
    modport master (
        output sw, btn,
        input  clear_pulse, load_time_pulse, load_alarm_pulse, stop_alarm_pulse,
        input  minute_out0, minute_out1, hour_out0, hour_out1,
        input  alarm_on, btn_level, sw_invalid
    );

    modport slave (
        input  sw, btn,
        output clear_pulse, load_time_pulse, load_alarm_pulse, stop_alarm_pulse,
        output minute_out0, minute_out1, hour_out0, hour_out1,
        output alarm_on, btn_level, sw_invalid
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises switches/buttons, debounces buttons into command pulses and
// range-checks the switch-coded HH:MM before handing it to the alarm clock core.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  reset,
    input_conditioner_if.slave   io
);

    localparam int RAW_W = 19;
    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [RAW_W-1:0] sync_q [SYNC_STAGES];
    logic [RAW_W-1:0] sync_v;
    logic [14:0]      sw_s;
    logic [3:0]       btn_s;

    logic [19:0] db_cnt [4];
    logic [3:0]  stable;
    logic [3:0]  stable_q;
    logic [3:0]  btn_edge;

    logic       sw_valid;
    logic       load_edge;
    logic       clear_pulse_q;
    logic       load_time_pulse_q;
    logic       load_alarm_pulse_q;
    logic       stop_alarm_pulse_q;
    logic [3:0] minute0_q;
    logic [3:0] minute1_q;
    logic [3:0] hour0_q;
    logic [1:0] hour1_q;
    logic       sw_invalid_q;

    assign sync_v = sync_q[SYNC_STAGES-1];
    assign sw_s   = sync_v[14:0];
    assign btn_s  = sync_v[18:15];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {io.btn, io.sw};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 4; b++) db_cnt[b] <= '0;
            stable   <= '0;
            stable_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (btn_s[b] == stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CNT_LAST) begin
                    stable[b] <= ~stable[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 20'd1;
                end
            end
            stable_q <= stable;
        end
    end

    assign btn_edge  = stable & ~stable_q;
    assign load_edge = btn_edge[1] | btn_edge[2];

    assign sw_valid = (sw_s[3:0] <= 4'd9) && (sw_s[7:4] <= 4'd5) &&
                      (sw_s[11:8] <= 4'd9) && (sw_s[13:12] <= 2'd2) &&
                      !((sw_s[13:12] == 2'd2) && (sw_s[11:8] > 4'd3));

    // Clear wins over a coincident load; stop is handled on its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_pulse_q      <= 1'b0;
            load_time_pulse_q  <= 1'b0;
            load_alarm_pulse_q <= 1'b0;
            stop_alarm_pulse_q <= 1'b0;
            minute0_q          <= '0;
            minute1_q          <= '0;
            hour0_q            <= '0;
            hour1_q            <= '0;
            sw_invalid_q       <= 1'b0;
        end else begin
            clear_pulse_q      <= 1'b0;
            load_time_pulse_q  <= 1'b0;
            load_alarm_pulse_q <= 1'b0;
            stop_alarm_pulse_q <= btn_edge[3];
            if (btn_edge[0]) begin
                clear_pulse_q <= 1'b1;
                sw_invalid_q  <= 1'b0;
            end else if (load_edge) begin
                if (sw_valid) begin
                    minute0_q          <= sw_s[3:0];
                    minute1_q          <= sw_s[7:4];
                    hour0_q            <= sw_s[11:8];
                    hour1_q            <= sw_s[13:12];
                    load_time_pulse_q  <= btn_edge[1];
                    load_alarm_pulse_q <= btn_edge[2];
                    sw_invalid_q       <= 1'b0;
                end else begin
                    sw_invalid_q <= 1'b1;
                end
            end
        end
    end

    assign io.clear_pulse      = clear_pulse_q;
    assign io.load_time_pulse  = load_time_pulse_q;
    assign io.load_alarm_pulse = load_alarm_pulse_q;
    assign io.stop_alarm_pulse = stop_alarm_pulse_q;
    assign io.minute_out0      = minute0_q;
    assign io.minute_out1      = minute1_q;
    assign io.hour_out0        = hour0_q;
    assign io.hour_out1        = hour1_q;
    assign io.alarm_on         = sw_s[14];
    assign io.btn_level        = stable;
    assign io.sw_invalid       = sw_invalid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with short debounce so button latency is 7 cycles.
module tb_input_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_conditioner_if io ();

    input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // event = {clear, load_time, load_alarm, stop, hour1, hour0, min1, min0, sw_invalid}
    logic [18:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [18:0] mon_got;
    logic [18:0] mon_exp;
    int          mon_cyc;

    logic [1:0] m_h1;
    logic [3:0] m_h0, m_m1, m_m0;
    logic       m_inv;
    logic [1:0] c_h1;
    logic [3:0] c_h0, c_m1, c_m0;
    logic       c_alarm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic valid_time(input logic [1:0] h1, input logic [3:0] h0,
                                        input logic [3:0] m1, input logic [3:0] m0);
        return (m0 < 4'd10) && (m1 < 4'd6) && (h0 < 4'd10) &&
               ((h1 < 2'd2) || ((h1 == 2'd2) && (h0 < 4'd4)));
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon_got = {io.clear_pulse, io.load_time_pulse, io.load_alarm_pulse, io.stop_alarm_pulse,
                       io.hour_out1, io.hour_out0, io.minute_out1, io.minute_out0, io.sw_invalid};
            if (mon_got[18:15] != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(mon_got[18:15]), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_cyc = exp_cyc_q.pop_front();
                    check("pulse_evt", 32'(mon_got), 32'(mon_exp));
                    check("pulse_cyc", 32'(cyc), 32'(mon_cyc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
        c_h1 = h1; c_h0 = h0; c_m1 = m1; c_m0 = m0;
        io.sw = {c_alarm, h1, h0, m1, m0};
        tick(SYNC + 1);
    endtask

    // Updates the reference model for a press that starts now and queues its pulse event.
    task automatic expect_press(input logic [3:0] mask);
        logic clr, ld, ok, lt, la;
        clr = mask[0];
        ld  = (mask[1] | mask[2]) & ~clr;
        ok  = valid_time(c_h1, c_h0, c_m1, c_m0);
        lt  = 1'b0;
        la  = 1'b0;
        if (clr) begin
            m_inv = 1'b0;
        end else if (ld) begin
            if (ok) begin
                m_h1 = c_h1; m_h0 = c_h0; m_m1 = c_m1; m_m0 = c_m0;
                m_inv = 1'b0;
                lt = mask[1];
                la = mask[2];
            end else begin
                m_inv = 1'b1;
            end
        end
        if (clr | mask[3] | (ld & ok)) begin
            exp_q.push_back({clr, lt, la, mask[3], m_h1, m_h0, m_m1, m_m0, m_inv});
            exp_cyc_q.push_back(cyc + LAT);
        end
    endtask

    task automatic finish_press(input logic [3:0] mask, input int hold);
        tick(hold);
        check("btn_level_held", 32'(io.btn_level), 32'(mask));
        io.btn = io.btn & ~mask;
        tick(LAT + 3);
        check("btn_level_rel", 32'(io.btn_level), 32'd0);
        check("pulse_seen", 32'(exp_q.size()), 32'd0);
        check("time_out", 32'({io.hour_out1, io.hour_out0, io.minute_out1, io.minute_out0}),
              32'({m_h1, m_h0, m_m1, m_m0}));
        check("sw_invalid", 32'(io.sw_invalid), 32'(m_inv));
    endtask

    task automatic do_press(input logic [3:0] mask, input int hold);
        expect_press(mask);
        io.btn = io.btn | mask;
        finish_press(mask, hold);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({io.clear_pulse, io.load_time_pulse, io.load_alarm_pulse,
                                  io.stop_alarm_pulse, io.alarm_on, io.btn_level, io.sw_invalid}), 32'd0);
        check({tag, "_time"}, 32'({io.hour_out1, io.hour_out0, io.minute_out1, io.minute_out0}), 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        io.sw   = '0;
        io.btn  = '0;
        c_alarm = 1'b0;
        c_h1 = '0; c_h0 = '0; c_m1 = '0; c_m0 = '0;
        m_h1 = '0; m_h0 = '0; m_m1 = '0; m_m0 = '0; m_inv = 1'b0;

        tick(3);
        check_all_zero("reset_state");
        reset = 1'b1;
        tick(2);

        // 3-cycle glitch on stop must be filtered
        io.btn[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("glitch_level", 32'(io.btn_level), 32'd0);
        end
        io.btn[3] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_after", 32'(io.btn_level), 32'd0);
        end
        do_press(4'b1000, 10);

        // alarm_on lags sw[14] by SYNC cycles
        c_alarm = 1'b1;
        io.sw[14] = 1'b1;
        tick(SYNC - 1);
        check("alarm_lag", 32'(io.alarm_on), 32'd0);
        tick(1);
        check("alarm_on", 32'(io.alarm_on), 32'd1);
        c_alarm = 1'b0;
        io.sw[14] = 1'b0;
        tick(SYNC - 1);
        check("alarm_off_lag", 32'(io.alarm_on), 32'd1);
        tick(1);
        check("alarm_off", 32'(io.alarm_on), 32'd0);

        set_sw(2'd2, 4'd3, 4'd5, 4'd9);
        do_press(4'b0010, 10);
        set_sw(2'd2, 4'd4, 4'd0, 4'd0);
        do_press(4'b0100, 10);
        set_sw(2'd1, 4'd2, 4'd6, 4'd0);
        do_press(4'b0100, 10);
        set_sw(2'd1, 4'hA, 4'd0, 4'd0);
        do_press(4'b0100, 10);
        set_sw(2'd1, 4'd2, 4'd3, 4'd4);
        do_press(4'b0100, 10);

        set_sw(2'd0, 4'd7, 4'd3, 4'd0);
        do_press(4'b0110, 10);
        set_sw(2'd2, 4'd4, 4'd0, 4'd0);
        do_press(4'b0100, 10);
        set_sw(2'd1, 4'd1, 4'd1, 4'd1);
        do_press(4'b0111, 10);

        for (int i = 0; i < 6; i++) begin
            set_sw(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            do_press(4'($urandom_range(1, 15)), $urandom_range(LAT, LAT + 4));
        end

        // reset in the middle of a load debounce, button kept held through release
        set_sw(2'd1, 4'd2, 4'd3, 4'd4);
        do_press(4'b0100, 10);
        set_sw(2'd0, 4'd9, 4'd4, 4'd5);
        io.btn[1] = 1'b1;
        tick(SYNC + 2);
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid");
        m_h1 = '0; m_h0 = '0; m_m1 = '0; m_m0 = '0; m_inv = 1'b0;
        tick(2);
        check_all_zero("reset_hold");
        reset = 1'b1;
        expect_press(4'b0010);
        finish_press(4'b0010, 10);

        tick(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
